// File: rtl/aer_spike_encoder.sv
// Rate-coding frame encoder emitting four-phase AER events, one time step per full raster scan.
// Define ENCODER_LFSR_EN for stochastic LFSR coding instead of deterministic phase accumulators.
module aer_spike_encoder #(
  parameter int FM_W      = 16,
  parameter int FM_H      = 16,
  parameter int TIME_STEP = 8,
  parameter int PIX_WIDTH = 8,
  localparam int NPIX     = FM_W * FM_H,
  localparam int AW       = $clog2(NPIX)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 START,
  input  logic                 PIXEL_WE,
  input  logic [AW-1:0]        PIXEL_WADDR,
  input  logic [PIX_WIDTH-1:0] PIXEL_WDATA,
  output logic                 AEROUT_REQ,
  output logic [AW-1:0]        AEROUT_ADDR,
  input  logic                 AEROUT_ACK,
  output logic                 BUSY,
  output logic                 STEP_DONE,
  output logic                 DONE
);

  localparam int SW = (TIME_STEP > 1) ? $clog2(TIME_STEP) : 1;

  typedef enum logic [2:0] {IDLE, SCAN, REQ, ACK_LOW, STEP_END, FIN} state_t;

  state_t               state_q, state_d;
  logic [AW-1:0]        idx_q;
  logic [SW-1:0]        step_q;
  logic [PIX_WIDTH-1:0] pix_mem [NPIX];
  logic [PIX_WIDTH-1:0] pix_cur;
  logic                 spike;
  logic                 start_run, scan_en, advance;
  logic                 last_pix, last_step;

  assign pix_cur   = pix_mem[idx_q];
  assign last_pix  = (idx_q == AW'(NPIX - 1));
  assign last_step = (step_q == SW'(TIME_STEP - 1));

  // NOTE: pixel storage has no reset; clearing a frame buffer costs a wide reset tree and buys nothing.
  always_ff @(posedge clk) begin
    if (PIXEL_WE && state_q == IDLE)
      pix_mem[PIXEL_WADDR] <= PIXEL_WDATA;
  end

`ifdef ENCODER_LFSR_EN
  logic [15:0] lfsr_q;
  logic        lfsr_fb;

  assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
  assign spike   = pix_cur > lfsr_q[PIX_WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (rst || (start_run))
      lfsr_q <= 16'hACE1;
    else if (scan_en)
      lfsr_q <= {lfsr_q[14:0], lfsr_fb};
  end
`else
  localparam logic [PIX_WIDTH:0] FS_EXT = {1'b0, {PIX_WIDTH{1'b1}}};

  logic [PIX_WIDTH-1:0] acc_q [NPIX];
  logic [PIX_WIDTH:0]   sum;
  logic [PIX_WIDTH-1:0] acc_next;

  // One extra bit keeps acc+pix exact; the residue after a spike is always below FS.
  assign sum      = {1'b0, acc_q[idx_q]} + {1'b0, pix_cur};
  assign spike    = (sum >= FS_EXT);
  assign acc_next = spike ? PIX_WIDTH'(sum - FS_EXT) : sum[PIX_WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (rst || start_run) begin
      for (int i = 0; i < NPIX; i++) acc_q[i] <= '0;
    end else if (scan_en) begin
      acc_q[idx_q] <= acc_next;
    end
  end
`endif

  // NOTE: every register is updated with <= so all flops see pre-edge values regardless of block order.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    start_run = 1'b0;
    scan_en   = 1'b0;
    advance   = 1'b0;
    unique case (state_q)
      IDLE: if (START) begin
        start_run = 1'b1;
        state_d   = SCAN;
      end
      SCAN: begin
        scan_en = 1'b1;
        if (spike)         state_d = REQ;
        else if (last_pix) state_d = STEP_END;
        else               advance = 1'b1;
      end
      REQ: if (AEROUT_ACK) state_d = ACK_LOW;
      ACK_LOW: if (!AEROUT_ACK) begin
        if (last_pix) state_d = STEP_END;
        else begin
          advance = 1'b1;
          state_d = SCAN;
        end
      end
      STEP_END: state_d = last_step ? FIN : SCAN;
      FIN:      state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || start_run) begin
      idx_q  <= '0;
      step_q <= '0;
    end else if (state_q == STEP_END) begin
      idx_q  <= '0;
      step_q <= step_q + 1'b1;
    end else if (advance) begin
      idx_q  <= idx_q + 1'b1;
    end
  end

  // The index register doubles as the event address; it is frozen throughout a handshake.
  assign AEROUT_REQ  = (state_q == REQ);
  assign AEROUT_ADDR = idx_q;
  assign BUSY        = (state_q != IDLE);
  assign STEP_DONE   = (state_q == STEP_END);
  assign DONE        = (state_q == FIN);

endmodule

// File: tb/tb_aer_spike_encoder.sv
// Directed bench for aer_spike_encoder: a frame-level rate-coding model predicts the event stream,
// and a per-cycle monitor checks addresses, handshake stability and per-step event counts.
module tb_aer_spike_encoder;

  localparam int N     = 256;
  localparam int T     = 8;
  localparam int FS    = 255;
  localparam int LIMIT = 10000;

  logic       clk = 1'b0;
  logic       rst, START, PIXEL_WE, AEROUT_REQ, AEROUT_ACK, BUSY, STEP_DONE, DONE;
  logic [7:0] PIXEL_WADDR, AEROUT_ADDR;
  logic [7:0] PIXEL_WDATA;

  aer_spike_encoder dut (
    .clk(clk), .rst(rst), .START(START), .PIXEL_WE(PIXEL_WE),
    .PIXEL_WADDR(PIXEL_WADDR), .PIXEL_WDATA(PIXEL_WDATA),
    .AEROUT_REQ(AEROUT_REQ), .AEROUT_ADDR(AEROUT_ADDR), .AEROUT_ACK(AEROUT_ACK),
    .BUSY(BUSY), .STEP_DONE(STEP_DONE), .DONE(DONE)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s", name);
  endtask

  // Frame-level model: rate coding with per-pixel phase accumulators across T steps.
  int frm [N];
  int exp_q [$];
  int exp_step_cnt [T];
  int exp_pix_cnt [N];

  function automatic void build_model();
    int acc [N];
    exp_q.delete();
    for (int p = 0; p < N; p++) begin acc[p] = 0; exp_pix_cnt[p] = 0; end
    for (int s = 0; s < T; s++) begin
      exp_step_cnt[s] = 0;
      for (int p = 0; p < N; p++) begin
        acc[p] += frm[p];
        if (acc[p] >= FS) begin
          acc[p] -= FS;
          exp_q.push_back(p);
          exp_step_cnt[s]++;
          exp_pix_cnt[p]++;
        end
      end
    end
  endfunction

  // Four-phase responder: acknowledges after ack_delay cycles of observed request.
  int ack_delay = 0;
  bit ack_hold  = 1'b0;

  initial begin
    int cnt = 0;
    AEROUT_ACK = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        AEROUT_ACK = 1'b0;
        cnt = 0;
      end else if (!AEROUT_ACK) begin
        if (AEROUT_REQ && !ack_hold) begin
          cnt++;
          if (cnt > ack_delay) begin AEROUT_ACK = 1'b1; cnt = 0; end
        end
      end else if (!AEROUT_REQ) begin
        AEROUT_ACK = 1'b0;
      end
    end
  end

  // Monitor: every cycle while a run is in progress.
  bit         mon_en = 1'b0;
  logic       prev_req = 1'b0, prev_ack = 1'b0;
  logic [7:0] held_addr;
  int         step_seen, ev_in_step, hold, min_hold;

  always @(negedge clk) begin
    if (mon_en) begin
      if (AEROUT_REQ && !prev_req) begin
        check("ack_low_before_req", int'(prev_ack), 0);
        if (exp_q.size() == 0) fail("unexpected_event");
        else check("event_addr", int'(AEROUT_ADDR), exp_q.pop_front());
        held_addr = AEROUT_ADDR;
        hold = 0;
        ev_in_step++;
      end else if (AEROUT_REQ) begin
        check("addr_stable", int'(AEROUT_ADDR), int'(held_addr));
      end
      if (AEROUT_REQ && !AEROUT_ACK) hold++;
      if (!AEROUT_REQ && prev_req && hold < min_hold) min_hold = hold;
      if (STEP_DONE) begin
        if (step_seen < T) check("events_in_step", ev_in_step, exp_step_cnt[step_seen]);
        else fail("extra_step_done");
        step_seen++;
        ev_in_step = 0;
      end
      if (DONE) begin
        check("steps_at_done", step_seen, T);
        check("events_left_at_done", exp_q.size(), 0);
      end
    end
    prev_req = AEROUT_REQ;
    prev_ack = AEROUT_ACK;
  end

  task automatic load_frame();
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      PIXEL_WE = 1'b1;
      PIXEL_WADDR = 8'(i);
      PIXEL_WDATA = 8'(frm[i]);
    end
    @(negedge clk);
    PIXEL_WE = 1'b0;
  endtask

  task automatic run_frame(input int delay, input bit disturb, output int cyc);
    ack_delay  = delay;
    step_seen  = 0;
    ev_in_step = 0;
    hold       = 0;
    min_hold   = 1000000;
    build_model();
    @(negedge clk);
    mon_en = 1'b1;
    START  = 1'b1;
    cyc = 0;
    while (!DONE && cyc < LIMIT) begin
      @(negedge clk);
      cyc++;
      START = 1'b0;
      PIXEL_WE = 1'b0;
      if (cyc == 1) check("busy_after_start", int'(BUSY), 1);
      if (disturb && (cyc == 300 || cyc == 1500)) begin
        PIXEL_WE = 1'b1;
        PIXEL_WADDR = 8'd0;
        PIXEL_WDATA = 8'd255;
        START = 1'b1;
      end
    end
    if (!DONE) fail("done_timeout");
    @(negedge clk);
    check("busy_after_done", int'(BUSY), 0);
    check("done_is_pulse", int'(DONE), 0);
    #1 mon_en = 1'b0;
  endtask

  initial begin
    int cyc;
    rst = 1'b1; START = 1'b0; PIXEL_WE = 1'b0; PIXEL_WADDR = '0; PIXEL_WDATA = '0;
    repeat (3) @(negedge clk);
    check("rst_req", int'(AEROUT_REQ), 0);
    check("rst_addr", int'(AEROUT_ADDR), 0);
    check("rst_busy", int'(BUSY), 0);
    check("rst_step_done", int'(STEP_DONE), 0);
    check("rst_done", int'(DONE), 0);
    rst = 1'b0;

    // All-zero frame: no events, eight steps, scan-dominated latency.
    for (int i = 0; i < N; i++) frm[i] = 0;
    load_frame();
    build_model();
    check("model_zero_events", exp_q.size(), 0);
    run_frame(0, 1'b0, cyc);
    check("zero_latency_in_range", int'(cyc >= N*T && cyc <= N*T + 4*T + 8), 1);

    // Single full-scale pixel fires every step.
    frm[5] = 255;
    load_frame();
    build_model();
    check("model_fs_events", exp_q.size(), 8);
    check("model_fs_pix5", exp_pix_cnt[5], 8);
    run_frame(0, 1'b0, cyc);

    // Half and quarter scale: pixel 0 on steps 2,4,6,8; pixel 255 on steps 4,8.
    frm[5] = 0; frm[0] = 128; frm[255] = 64;
    load_frame();
    build_model();
    check("model_pix0_events", exp_pix_cnt[0], 4);
    check("model_pix255_events", exp_pix_cnt[255], 2);
    check("model_step1_events", exp_step_cnt[0], 0);
    check("model_step2_events", exp_step_cnt[1], 1);
    check("model_step4_events", exp_step_cnt[3], 2);
    run_frame(0, 1'b0, cyc);

    // Slow acknowledge: request and address held for the full delay.
    run_frame(10, 1'b0, cyc);
    check("req_hold_cycles", min_hold, 10);

    // Reset in the middle of a handshake, then a clean re-encode from step 0.
    frm[0] = 0; frm[255] = 0; frm[5] = 255;
    load_frame();
    ack_hold = 1'b1;
    @(negedge clk) START = 1'b1;
    @(negedge clk) START = 1'b0;
    cyc = 0;
    while (!AEROUT_REQ && cyc < 1000) begin @(negedge clk); cyc++; end
    if (!AEROUT_REQ) fail("req_timeout_before_reset");
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midhs_rst_req", int'(AEROUT_REQ), 0);
    check("midhs_rst_busy", int'(BUSY), 0);
    check("midhs_rst_addr", int'(AEROUT_ADDR), 0);
    @(negedge clk);
    rst = 1'b0;
    ack_hold = 1'b0;
    run_frame(0, 1'b0, cyc);

    // Writes and START during BUSY must not perturb the event stream, nor the stored frame.
    frm[5] = 0; frm[0] = 128; frm[255] = 64;
    load_frame();
    run_frame(0, 1'b1, cyc);
    run_frame(0, 1'b0, cyc);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
